// File: rtl/per_rx_fifo_if.sv
// Bundle of the CPU send/ack handshake and the peripheral valid/ready output
// side of the receive FIFO, plus its status outputs.
interface per_rx_fifo_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
);
    logic              per_send;
    logic [DATA_W-1:0] in_per_dados;
    logic              per_ack;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_dados;
    logic [CNT_W-1:0]  per_count;
    logic              per_full;
    logic [7:0]        per_total;

    modport master (
        output per_send, in_per_dados, out_ready,
        input  per_ack, out_valid, out_dados, per_count, per_full, per_total
    );

    modport slave (
        input  per_send, in_per_dados, out_ready,
        output per_ack, out_valid, out_dados, per_count, per_full, per_total
    );
endinterface

// File: rtl/per_rx_fifo.sv
// Peripheral receive buffer: terminates the 4-phase send/ack handshake and
// queues accepted words in a first-word-fall-through FIFO with valid/ready.
module per_rx_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic          per_clock,
    input  logic          per_reset,
    per_rx_fifo_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t            state_q;
    logic              ack_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        total_q, total_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic full;
    logic valid;
    logic push;
    logic pop;

    // Full and valid come from the registered count only, so a pop never
    // frees a slot for a push in the same cycle.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign valid = (count_q != '0);
    assign push  = (state_q == IDLE) && bus.per_send && !full;
    assign pop   = valid && bus.out_ready;

    always_ff @(posedge per_clock or negedge per_reset) begin
        if (!per_reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ACK: begin
                    if (!bus.per_send) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        total_d  = total_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            total_d  = total_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge per_clock or negedge per_reset) begin
        if (!per_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            total_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            total_q  <= total_d;
        end
    end

    // Storage carries no reset; stale entries are masked by out_valid.
    always_ff @(posedge per_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_per_dados;
        end
    end

    assign bus.per_ack   = ack_q;
    assign bus.out_valid = valid;
    assign bus.out_dados = valid ? mem_q[rd_ptr_q] : '0;
    assign bus.per_count = count_q;
    assign bus.per_full  = full;
    assign bus.per_total = total_q;
endmodule

// File: tb/tb_per_rx_fifo.sv
// Bench for per_rx_fifo: table-driven streaming plus hand-written corner
// sequences, with a scoreboard queue checked on every pop.
module tb_per_rx_fifo;
    logic clk;
    logic rst_n;

    per_rx_fifo_if #(.DATA_W(4), .DEPTH(4)) bus ();

    per_rx_fifo #(.DATA_W(4), .DEPTH(4)) dut (
        .per_clock (clk),
        .per_reset (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;
    int exp_total;
    int max_cnt;
    bit stream_on;
    logic [3:0] exp_q [$];

    typedef struct {
        logic [3:0] data;
        logic       ready;
        int         exp_count;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
            $display("check %-14s got %0d expected %0d ok", name, act, exp);
        end else begin
            $display("FAIL %-14s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every pop seen on the output side is compared to the queue.
    always @(negedge clk) begin
        if (stream_on && int'(bus.per_count) > max_cnt) max_cnt = int'(bus.per_count);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_underflow", 1, 0);
            end else begin
                chk("pop_data", int'(bus.out_dados), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_ack(input logic val, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.per_ack == val) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, int'(seen), 1);
    endtask

    task automatic send_word(input logic [3:0] d, input int hold);
        @(posedge clk); #1;
        bus.per_send     = 1'b1;
        bus.in_per_dados = d;
        exp_q.push_back(d);
        exp_total++;
        wait_ack(1'b1, "ack_rise");
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        bus.per_send = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.per_count == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_empty", int'(done), 1);
        chk("sb_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int acks;
        int seq [6];
        n_total = 0; n_pass = 0; exp_total = 0; max_cnt = 0; stream_on = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tbl[i].data      = 4'(i % 16);
            tbl[i].ready     = 1'b1;
            tbl[i].exp_count = 0;
        end
        seq = '{0, 1, 1, 1, 1, 0};

        // 1: reset
        rst_n = 1'b0;
        bus.per_send = 1'b0; bus.in_per_dados = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ack",   int'(bus.per_ack),   0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_dados", int'(bus.out_dados), 0);
        chk("rst_count", int'(bus.per_count), 0);
        chk("rst_full",  int'(bus.per_full),  0);
        chk("rst_total", int'(bus.per_total), 0);
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.per_ack) acks++;
        end
        chk("idle_no_ack", acks, 0);

        // 2: single transfer, ack timing
        @(posedge clk); #1;
        bus.per_send = 1'b1; bus.in_per_dados = 4'hA;
        exp_q.push_back(4'hA); exp_total++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_ack_seq", int'(bus.per_ack), seq[i]);
            if (i == 3) begin
                @(posedge clk); #1;
                bus.per_send = 1'b0;
            end
        end
        chk("t2_valid", int'(bus.out_valid), 1);
        chk("t2_dados", int'(bus.out_dados), 'hA);
        chk("t2_count", int'(bus.per_count), 1);
        chk("t2_total", int'(bus.per_total), exp_total);
        drain();

        // 3: full backpressure
        for (int w = 1; w <= 4; w++) send_word(4'(w), 0);
        chk("t3_count", int'(bus.per_count), 4);
        chk("t3_full",  int'(bus.per_full),  1);
        @(posedge clk); #1;
        bus.per_send = 1'b1; bus.in_per_dados = 4'h5;
        exp_q.push_back(4'h5); exp_total++;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.per_ack) acks++;
        end
        chk("t3_withheld", acks, 0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t3_ack_p1",   int'(bus.per_ack),   0);
        chk("t3_count_p1", int'(bus.per_count), 3);
        @(negedge clk);
        chk("t3_ack_p2",   int'(bus.per_ack),   1);
        chk("t3_count_p2", int'(bus.per_count), 4);
        @(posedge clk); #1 bus.per_send = 1'b0;
        wait_ack(1'b0, "t3_ack_fall");
        drain();

        // 4: streaming from the vector table
        max_cnt = 0;
        stream_on = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 bus.out_ready = tbl[i].ready;
            send_word(tbl[i].data, 0);
            chk("t4_count", int'(bus.per_count), tbl[i].exp_count);
        end
        stream_on = 1'b0;
        chk("t4_max_count", max_cnt, 1);
        chk("t4_total", int'(bus.per_total), exp_total & 255);
        @(posedge clk); #1 bus.out_ready = 1'b0;
        chk("t4_sb_empty", exp_q.size(), 0);

        // 5: simultaneous push and pop at count 2
        send_word(4'h8, 0);
        send_word(4'h9, 0);
        chk("t5_count_pre", int'(bus.per_count), 2);
        @(posedge clk); #1;
        bus.per_send = 1'b1; bus.in_per_dados = 4'hC; bus.out_ready = 1'b1;
        exp_q.push_back(4'hC); exp_total++;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t5_count", int'(bus.per_count), 2);
        chk("t5_head",  int'(bus.out_dados), 'h9);
        chk("t5_ack",   int'(bus.per_ack),   1);
        @(posedge clk); #1 bus.per_send = 1'b0;
        wait_ack(1'b0, "t5_ack_fall");
        chk("t5_total", int'(bus.per_total), exp_total & 255);
        drain();

        // 6: reset while in ACK with count 3
        send_word(4'h1, 0);
        send_word(4'h2, 0);
        @(posedge clk); #1;
        bus.per_send = 1'b1; bus.in_per_dados = 4'h7;
        wait_ack(1'b1, "t6_ack_rise");
        chk("t6_count_pre", int'(bus.per_count), 3);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("t6_ack_async", int'(bus.per_ack),   0);
        chk("t6_count_rst", int'(bus.per_count), 0);
        chk("t6_total_rst", int'(bus.per_total), 0);
        exp_q.delete();
        exp_total = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(4'h7); exp_total++;
        wait_ack(1'b1, "t6_recapture");
        chk("t6_total", int'(bus.per_total), exp_total);
        chk("t6_count", int'(bus.per_count), 1);
        chk("t6_dados", int'(bus.out_dados), 'h7);
        @(posedge clk); #1 bus.per_send = 1'b0;
        wait_ack(1'b0, "t6_ack_fall");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
